memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline stage directly downstream of the execute stage. It holds the EX/MEM pipeline register and drives a request/acknowledge data-memory port. It performs byte-lane alignment for stores and extraction plus sign/zero extension for loads. It stalls the pipeline while a memory access is outstanding, and returns the registered ALU result to execute-stage forwarding.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; byte-lane logic is fixed at 4 lanes (32 only)
- ADDRESS_WIDTH, 32, memory address width
- RF_ADDR_WIDTH, 5, register-file address width

Ports (clock and reset first):
- i_CLK  in  1  single clock, rising edge
- i_RST_n  in  1  asynchronous, active-low reset
- i_ALUOutE  in  DATA_WIDTH  execute ALU result (effective address or ALU value)
- i_WriteDataE  in  DATA_WIDTH  forwarded store data from execute
- i_WriteRegE  in  RF_ADDR_WIDTH  destination register
- i_RegWriteE, i_MemToRegE, i_MemReadE, i_MemWriteE  in  1 each  control bits
- i_MemSizeE  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_MemSignedE  in  1  sign-extend loads when 1
- i_FlushE  in  1  load a bubble (all control bits 0) instead of execute outputs
- o_ALUOutM  out  DATA_WIDTH  registered ALU result; also the forwarding source for execute
- o_WriteRegM  out  RF_ADDR_WIDTH  registered destination
- o_RegWriteM, o_MemToRegM  out  1 each  registered control bits
- o_ReadDataM  out  DATA_WIDTH  aligned and extended load data
- o_StallM  out  1  freeze the PC, IF/ID, ID/EX and this stage's register
- o_DmemReq, o_DmemWe  out  1 each  memory request and write enable
- o_DmemAddr  out  ADDRESS_WIDTH  word-aligned address (bits [1:0] = 0)
- o_DmemWData  out  DATA_WIDTH  lane-replicated store data
- o_DmemBe  out  4  byte enables
- i_DmemAck  in  1  request accepted/completed this cycle
- i_DmemRData  in  DATA_WIDTH  read data, valid with i_DmemAck

## Operation
- EX/MEM register loads at each rising edge when o_StallM=0. With i_FlushE=1 it loads a bubble: control bits 0, data 0.
- memop = MemReadM | MemWriteM.
- FSM states and transitions:
  - IDLE: o_DmemReq = memop. memop & ack -> DONE; memop & !ack -> WAIT.
  - WAIT: request held with address, data and byte enables stable. ack -> DONE.
  - DONE: request low. On ack, read data was captured into the read-data register. Next edge -> IDLE, and the EX/MEM register advances.
- o_StallM = memop & (state != DONE).
- Store alignment, with a = ALUOutM[1:0]:
  - byte: data replicated ×4, Be = 1<<a
  - half: data replicated ×2, Be = a[1] ? 1100 : 0011
  - word: Be = 1111
  - o_DmemWe = MemWriteM
- Load extraction uses the same lane select, then sign- or zero-extends per MemSignedM. On a store, o_ReadDataM is 0.
- Simultaneous MemRead and MemWrite are treated as a write.
- Reset asserted mid-access: the FSM returns to IDLE and o_DmemReq drops immediately (asynchronously). The access is abandoned and no retry is made.

## Timing
- Reset values:
  - all registered outputs and the read-data register are 0
  - state = IDLE
  - o_DmemReq = 0, o_StallM = 0, o_DmemBe = 0000
- Non-memory op: zero stall; it occupies M for one cycle.
- Memory op with the earliest possible ack (ack in the op's first M cycle): 1 stall cycle. o_ReadDataM is valid in the DONE cycle, and the op leaves M at the edge ending DONE.
- Each additional cycle without ack adds one stall cycle.
- Back-to-back memory ops: each costs at least 2 cycles in M. o_DmemReq is low for exactly one cycle (DONE) between them.
- A flush during a stall is ignored, because the register is frozen. The hazard unit must not assert both.

## Configuration
- MEM_MISALIGN_EXC_EN defined: a misaligned access (half with a[0]=1, word with a≠00) does not raise o_DmemReq and does not stall. It asserts o_AddrExcM (extra 1-bit output) for its single M cycle and forces o_RegWriteM=0.
- Undefined: no o_AddrExcM port. Low address bits below the access size are ignored (forced alignment) and the access proceeds normally.

## Structure
- Shared package mem_stage_pkg holds:
  - size encodings MEM_BYTE/MEM_HALF/MEM_WORD
  - FSM state encoding ST_IDLE/ST_WAIT/ST_DONE
  - byte-enable constants
- One combinational sub-module, load_store_align, produces WData/Be and the extracted, extended load data from size, signed and addr[1:0]. The FSM and pipeline register stay in the top module.

## Test plan
- Word store, ALUOutE=0x1004, WriteDataE=0xDEADBEEF, ack in the same cycle -> Addr=0x1004, Be=1111, We=1, o_StallM high for 1 cycle, op leaves M after 2 cycles.
- Signed byte load at 0x2003, RData=0x80FF1234, ack delayed 3 cycles -> o_StallM high for 4 cycles, o_ReadDataM=0xFFFFFF80.
- Unsigned half load at 0x2002, RData=0x80FF1234 -> o_ReadDataM=0x000080FF. Byte store of 0xAB at offset 1 -> WData=0xABABABAB, Be=0010.
- ALU op (RegWrite=1, no memop) followed by i_FlushE -> zero stall, o_ALUOutM forwarded the next cycle, then a bubble with o_RegWriteM=0.
- i_RST_n pulled low while in WAIT -> o_DmemReq=0 and o_StallM=0 with no clock edge, state IDLE after release.
- With MEM_MISALIGN_EXC_EN, word load at 0x3002 -> o_DmemReq stays 0, o_AddrExcM=1 for one cycle, o_RegWriteM=0. Without the macro -> Addr=0x3000, normal load.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the memory access stage
// Holds access-size codes, handshake FSM states and byte-enable constants.
package mem_stage_pkg;
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [3:0] BE_NONE  = 4'b0000;
    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_LO    = 4'b0011;
    localparam logic [3:0] BE_HI    = 4'b1100;
    localparam logic [3:0] BE_ALL   = 4'b1111;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte-lane alignment for stores and lane extraction/extension for loads
// Ports: size/sign_ext/addr select the lanes; store_data -> wdata/be; load_raw -> load_data.
// Size 11 behaves as a word; address bits below the access size are ignored.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  addr,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);
    logic [7:0]  lb;
    logic [15:0] lh;
    always_comb begin
        lb = load_raw[{addr, 3'b000} +: 8];
        lh = addr[1] ? load_raw[31:16] : load_raw[15:0];
        wdata = size == MEM_BYTE ? {4{store_data[7:0]}} :
                size == MEM_HALF ? {2{store_data[15:0]}} : store_data;
        be = size == MEM_BYTE ? BE_BYTE0 << addr :
             size == MEM_HALF ? (addr[1] ? BE_HI : BE_LO) : BE_ALL;
        load_data = size == MEM_BYTE ? {{24{sign_ext & lb[7]}}, lb} :
                    size == MEM_HALF ? {{16{sign_ext & lh[15]}}, lh} : load_raw;
    end
endmodule

// File: rtl/memory_access_stage.sv
// memory_access_stage: EX/MEM register, data-memory req/ack FSM and load/store alignment
// Ports: i_CLK, i_RST_n (async active-low); i_*E execute results and controls, i_FlushE bubble;
//   o_*M registered results, o_ReadDataM aligned load data, o_StallM pipeline freeze;
//   o_Dmem*/i_Dmem* request/acknowledge data-memory port.
// Optional: MEM_MISALIGN_EXC_EN adds o_AddrExcM and suppresses misaligned accesses.
module memory_access_stage
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int RF_ADDR_WIDTH = 5
)(
    input  logic                     i_CLK,
    input  logic                     i_RST_n,
    input  logic [DATA_WIDTH-1:0]    i_ALUOutE,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataE,
    input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegE,
    input  logic                     i_RegWriteE,
    input  logic                     i_MemToRegE,
    input  logic                     i_MemReadE,
    input  logic                     i_MemWriteE,
    input  logic [1:0]               i_MemSizeE,
    input  logic                     i_MemSignedE,
    input  logic                     i_FlushE,
    output logic [DATA_WIDTH-1:0]    o_ALUOutM,
    output logic [RF_ADDR_WIDTH-1:0] o_WriteRegM,
    output logic                     o_RegWriteM,
    output logic                     o_MemToRegM,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_StallM,
    output logic                     o_DmemReq,
    output logic                     o_DmemWe,
    output logic [ADDRESS_WIDTH-1:0] o_DmemAddr,
    output logic [DATA_WIDTH-1:0]    o_DmemWData,
    output logic [3:0]               o_DmemBe,
`ifdef MEM_MISALIGN_EXC_EN
    output logic                     o_AddrExcM,
`endif
    input  logic                     i_DmemAck,
    input  logic [DATA_WIDTH-1:0]    i_DmemRData
);
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, load_data;
    logic [1:0] size_q, state, state_n;
    logic reg_write_q, mem_read_q, mem_write_q, signed_q, exc, memop;
    logic [3:0] be;
`ifdef MEM_MISALIGN_EXC_EN
    // Half needs a[0]=0; word (and reserved size) needs a=00.
    assign exc = (mem_read_q | mem_write_q) &
                 ((size_q == MEM_HALF & o_ALUOutM[0]) | (size_q[1] & |o_ALUOutM[1:0]));
    assign o_AddrExcM = exc;
`else
    assign exc = 1'b0;
`endif
    assign memop = (mem_read_q | mem_write_q) & ~exc;
    // Request and stall coincide: both are high until the DONE cycle.
    assign o_StallM = memop & (state != ST_DONE);
    assign o_DmemReq = o_StallM;
    assign o_DmemWe = mem_write_q & ~exc;
    assign o_DmemAddr = {o_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00};
    assign o_DmemBe = memop ? be : BE_NONE;
    assign o_RegWriteM = reg_write_q & ~exc;
    // A simultaneous read and write is a store, so no load data is returned.
    assign o_ReadDataM = (mem_read_q & ~mem_write_q) ? load_data : '0;
    assign state_n = state == ST_DONE ? ST_IDLE :
                     (memop & i_DmemAck) ? ST_DONE :
                     memop ? ST_WAIT : ST_IDLE;
    load_store_align u_align (
        .size       (size_q),
        .sign_ext   (signed_q),
        .addr       (o_ALUOutM[1:0]),
        .store_data (wdata_q),
        .load_raw   (rdata_q),
        .wdata      (o_DmemWData),
        .be         (be),
        .load_data  (load_data)
    );
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_ALUOutM   <= '0;
            o_WriteRegM <= '0;
            o_MemToRegM <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            size_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            signed_q    <= 1'b0;
            state       <= ST_IDLE;
        end else begin
            if (!o_StallM) begin
                o_ALUOutM   <= i_FlushE ? '0 : i_ALUOutE;
                o_WriteRegM <= i_FlushE ? '0 : i_WriteRegE;
                o_MemToRegM <= ~i_FlushE & i_MemToRegE;
                wdata_q     <= i_FlushE ? '0 : i_WriteDataE;
                size_q      <= i_FlushE ? '0 : i_MemSizeE;
                reg_write_q <= ~i_FlushE & i_RegWriteE;
                mem_read_q  <= ~i_FlushE & i_MemReadE;
                mem_write_q <= ~i_FlushE & i_MemWriteE;
                signed_q    <= ~i_FlushE & i_MemSignedE;
            end
            if (o_DmemReq && i_DmemAck) rdata_q <= i_DmemRData;
            state <= state_n;
        end
    end
endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: scoreboard bench for memory_access_stage
module tb_memory_access_stage;
    import mem_stage_pkg::*;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    logic clk = 0, rst_n = 0;
    logic [31:0] i_ALUOutE, i_WriteDataE, i_DmemRData;
    logic [4:0] i_WriteRegE;
    logic i_RegWriteE, i_MemToRegE, i_MemReadE, i_MemWriteE, i_MemSignedE, i_FlushE, i_DmemAck;
    logic [1:0] i_MemSizeE;
    logic [31:0] o_ALUOutM, o_ReadDataM, o_DmemAddr, o_DmemWData;
    logic [4:0] o_WriteRegM;
    logic o_RegWriteM, o_MemToRegM, o_StallM, o_DmemReq, o_DmemWe;
    logic [3:0] o_DmemBe;
`ifdef MEM_MISALIGN_EXC_EN
    logic o_AddrExcM;
`endif
    int checks = 0, failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    bit pend = 0;
    logic [31:0] pend_rd;
    always #5 clk = ~clk;
    memory_access_stage dut (
        .i_CLK(clk), .i_RST_n(rst_n),
        .i_ALUOutE(i_ALUOutE), .i_WriteDataE(i_WriteDataE), .i_WriteRegE(i_WriteRegE),
        .i_RegWriteE(i_RegWriteE), .i_MemToRegE(i_MemToRegE), .i_MemReadE(i_MemReadE),
        .i_MemWriteE(i_MemWriteE), .i_MemSizeE(i_MemSizeE), .i_MemSignedE(i_MemSignedE),
        .i_FlushE(i_FlushE),
        .o_ALUOutM(o_ALUOutM), .o_WriteRegM(o_WriteRegM), .o_RegWriteM(o_RegWriteM),
        .o_MemToRegM(o_MemToRegM), .o_ReadDataM(o_ReadDataM), .o_StallM(o_StallM),
        .o_DmemReq(o_DmemReq), .o_DmemWe(o_DmemWe), .o_DmemAddr(o_DmemAddr),
        .o_DmemWData(o_DmemWData), .o_DmemBe(o_DmemBe),
`ifdef MEM_MISALIGN_EXC_EN
        .o_AddrExcM(o_AddrExcM),
`endif
        .i_DmemAck(i_DmemAck), .i_DmemRData(i_DmemRData)
    );
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask
    // Monitor: checks every presented request against the scoreboard head; pops on ack
    // and then checks the DONE cycle (request low, load data) on the following sample.
    always @(negedge clk) begin
        if (!rst_n) pend = 0;
        else if (pend) begin
            chk("done_req_low", o_DmemReq, 0);
            chk("read_data", o_ReadDataM, pend_rd);
            pend = 0;
        end else if (o_DmemReq) begin
            if (sb.size() == 0) chk("unexpected_req", 1, 0);
            else begin
                mon_e = sb[0];
                chk("addr", o_DmemAddr, mon_e.addr);
                chk("we", o_DmemWe, mon_e.we);
                chk("be", o_DmemBe, mon_e.be);
                chk("wdata", o_DmemWData, mon_e.wdata);
                if (i_DmemAck) begin
                    void'(sb.pop_front());
                    pend = 1;
                    pend_rd = mon_e.rdata;
                end
            end
        end
    end
    task automatic nop();
        i_ALUOutE = 0; i_WriteDataE = 0; i_WriteRegE = 0; i_RegWriteE = 0; i_MemToRegE = 0;
        i_MemReadE = 0; i_MemWriteE = 0; i_MemSizeE = 0; i_MemSignedE = 0; i_FlushE = 0;
    endtask
    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic sg);
        i_ALUOutE = a; i_WriteDataE = wd; i_MemReadE = rd; i_MemWriteE = wr;
        i_MemSizeE = sz; i_MemSignedE = sg; i_RegWriteE = rd; i_MemToRegE = rd;
        i_WriteRegE = 5'd3; i_FlushE = 0;
    endtask
    task automatic mem_op(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                          input logic wr, input logic [1:0] sz, input logic sg, input int dly,
                          input logic [31:0] rdat, input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd, input int estall);
        exp_t x;
        int st = 0;
        bit done = 0;
        x = '{ea, wr, ebe, ewd, erd};
        sb.push_back(x);
        issue(a, wd, rd, wr, sz, sg);
        i_DmemRData = rdat;
        @(posedge clk); #1;
        nop();
        for (int c = 0; c < 40 && !done; c++) begin
            i_DmemAck = (c == dly);
            @(negedge clk);
            if (o_StallM) st++; else done = 1;
            @(posedge clk); #1;
            i_DmemAck = 0;
        end
        if (!done) chk("op_timeout", 1, 0);
        chk("stall_cycles", 32'(st), 32'(estall));
    endtask
    initial begin
        nop();
        i_DmemAck = 0; i_DmemRData = 0;
        #2;
        chk("rst_req", o_DmemReq, 0);
        chk("rst_stall", o_StallM, 0);
        chk("rst_be", o_DmemBe, 0);
        chk("rst_alu", o_ALUOutM, 0);
        chk("rst_rdata", o_ReadDataM, 0);
        chk("rst_regwrite", o_RegWriteM, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        mem_op(32'h1004, 32'hDEADBEEF, 0, 1, MEM_WORD, 0, 0, 0, 32'h1004, 4'b1111, 32'hDEADBEEF, 0, 1);
        mem_op(32'h2003, 0, 1, 0, MEM_BYTE, 1, 3, 32'h80FF1234, 32'h2000, 4'b1000, 0, 32'hFFFFFF80, 4);
        mem_op(32'h2002, 0, 1, 0, MEM_HALF, 0, 1, 32'h80FF1234, 32'h2000, 4'b1100, 0, 32'h000080FF, 2);
        mem_op(32'h2001, 32'h000000AB, 0, 1, MEM_BYTE, 0, 0, 0, 32'h2000, 4'b0010, 32'hABABABAB, 0, 1);
        mem_op(32'h0010, 32'h12345678, 0, 1, MEM_HALF, 0, 2, 0, 32'h0010, 4'b0011, 32'h56785678, 0, 3);
        mem_op(32'h0012, 0, 1, 0, MEM_HALF, 1, 0, 32'h9ABC0000, 32'h0010, 4'b1100, 0, 32'hFFFF9ABC, 1);
        mem_op(32'h0030, 0, 1, 0, MEM_BYTE, 0, 0, 32'h000000F0, 32'h0030, 4'b0001, 0, 32'h000000F0, 1);
        mem_op(32'h0020, 32'hCAFEF00D, 1, 1, MEM_WORD, 0, 0, 32'h11111111, 32'h0020, 4'b1111, 32'hCAFEF00D, 0, 1);
        mem_op(32'h0024, 0, 1, 0, 2'b11, 0, 0, 32'h89ABCDEF, 32'h0024, 4'b1111, 0, 32'h89ABCDEF, 1);
        // ALU op then flush
        i_ALUOutE = 32'h55; i_RegWriteE = 1; i_WriteRegE = 5'd7;
        @(posedge clk); #1;
        i_FlushE = 1; i_ALUOutE = 32'h66; i_WriteRegE = 5'd9;
        @(negedge clk);
        chk("alu_stall", o_StallM, 0);
        chk("alu_fwd", o_ALUOutM, 32'h55);
        chk("alu_regwrite", o_RegWriteM, 1);
        chk("alu_wreg", o_WriteRegM, 7);
        chk("alu_be", o_DmemBe, 0);
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        chk("bubble_regwrite", o_RegWriteM, 0);
        chk("bubble_alu", o_ALUOutM, 0);
        @(posedge clk); #1;
`ifdef MEM_MISALIGN_EXC_EN
        issue(32'h3002, 0, 1, 0, MEM_WORD, 0);
        @(posedge clk); #1;
        nop();
        @(negedge clk);
        chk("exc_flag", o_AddrExcM, 1);
        chk("exc_req", o_DmemReq, 0);
        chk("exc_stall", o_StallM, 0);
        chk("exc_regwrite", o_RegWriteM, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("exc_clear", o_AddrExcM, 0);
        @(posedge clk); #1;
`else
        mem_op(32'h3002, 0, 1, 0, MEM_WORD, 0, 0, 32'h11223344, 32'h3000, 4'b1111, 0, 32'h11223344, 1);
`endif
        // Reset while waiting for ack
        sb.push_back('{32'h0040, 1'b0, 4'b1111, 32'h0, 32'h0});
        issue(32'h0040, 0, 1, 0, MEM_WORD, 0);
        @(posedge clk); #1;
        nop();
        @(posedge clk); #1;
        chk("wait_req", o_DmemReq, 1);
        #2 rst_n = 0;
        #1;
        chk("rstw_req", o_DmemReq, 0);
        chk("rstw_stall", o_StallM, 0);
        chk("rstw_be", o_DmemBe, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_req", o_DmemReq, 0);
        chk("post_rst_stall", o_StallM, 0);
        @(posedge clk); #1;
        mem_op(32'h0044, 32'h01020304, 0, 1, MEM_WORD, 0, 1, 0, 32'h0044, 4'b1111, 32'h01020304, 0, 2);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
